// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: default widths, entry layout, opcodes.
// Optional same-cycle bypass is enabled by defining ALU_RS_BYPASS_EN.
package alu_rs_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int OP_W_DEF  = 4;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [OP_W_DEF-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic                 rdy;
    logic [XLEN_DEF-1:0]  val;
    logic [TAG_W_DEF-1:0] tag;
  } rs_src_t;

  typedef struct packed {
    logic                 valid;
    logic [OP_W_DEF-1:0]  opcode;
    logic [TAG_W_DEF-1:0] dst_tag;
    rs_src_t              src1;
    rs_src_t              src2;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_src_wakeup.sv
// One source-operand slot of a station entry: registers the next-state operand presented
// by the queue logic, folding in a CDB capture when the operand is still waiting.
module alu_rs_src_wakeup
  import alu_rs_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_rdy,
  input  logic [XLEN-1:0]  in_val,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             rdy,
  output logic [XLEN-1:0]  val,
  output logic [TAG_W-1:0] tag
);

  logic hit_s;

  assign hit_s = in_valid && !in_rdy && cdb_valid && (in_tag == cdb_tag);

  // operand register with CDB capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy <= 1'b0;
      val <= '0;
      tag <= '0;
    end else if (flush) begin
      rdy <= 1'b0;
      val <= '0;
      tag <= '0;
    end else begin
      rdy <= in_rdy || hit_s;
      val <= hit_s ? cdb_data : in_val;
      tag <= in_tag;
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: collapsing queue (entry 0 oldest), CDB wakeup, oldest-ready issue.
// Define ALU_RS_BYPASS_EN to let a ready dispatch into an empty station issue in the same cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_opcode,
  input  logic             disp_src1_rdy,
  input  logic [XLEN-1:0]  disp_src1_val,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic             disp_src2_rdy,
  input  logic [XLEN-1:0]  disp_src2_val,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic [TAG_W-1:0] disp_dst_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [OP_W-1:0]  iss_opcode,
  output logic [XLEN-1:0]  iss_src1,
  output logic [XLEN-1:0]  iss_src2,
  output logic [TAG_W-1:0] iss_dst_tag,
  output logic [CW-1:0]    count
);

  localparam int IW = $clog2(DEPTH);

  logic             valid_r   [DEPTH];
  logic [OP_W-1:0]  opcode_r  [DEPTH];
  logic [TAG_W-1:0] dst_r     [DEPTH];
  logic [CW-1:0]    count_r;

  logic             s1_rdy_s  [DEPTH];
  logic [XLEN-1:0]  s1_val_s  [DEPTH];
  logic [TAG_W-1:0] s1_tag_s  [DEPTH];
  logic             s2_rdy_s  [DEPTH];
  logic [XLEN-1:0]  s2_val_s  [DEPTH];
  logic [TAG_W-1:0] s2_tag_s  [DEPTH];

  logic             n_valid_s [DEPTH];
  logic [OP_W-1:0]  n_opcode_s[DEPTH];
  logic [TAG_W-1:0] n_dst_s   [DEPTH];
  logic             n1_rdy_s  [DEPTH];
  logic [XLEN-1:0]  n1_val_s  [DEPTH];
  logic [TAG_W-1:0] n1_tag_s  [DEPTH];
  logic             n2_rdy_s  [DEPTH];
  logic [XLEN-1:0]  n2_val_s  [DEPTH];
  logic [TAG_W-1:0] n2_tag_s  [DEPTH];

  logic             sel_found_s;
  logic [IW-1:0]    sel_idx_s;
  logic             iss_fire_s;
  logic             disp_fire_s;
  logic [CW-1:0]    wpos_s;

  assign count      = count_r;
  assign disp_ready = (count_r < CW'(DEPTH));
  assign iss_fire_s = sel_found_s && iss_ready;
  assign wpos_s     = count_r - (iss_fire_s ? CW'(1) : CW'(0));

`ifdef ALU_RS_BYPASS_EN
  logic bypass_s;
  assign bypass_s    = (count_r == '0) && disp_valid && disp_src1_rdy && disp_src2_rdy &&
                       iss_ready && !flush;
  assign disp_fire_s = disp_valid && disp_ready && !bypass_s;
`else
  assign disp_fire_s = disp_valid && disp_ready;
`endif

  // oldest ready entry: scan from the top so the lowest index wins
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_r[i] && s1_rdy_s[i] && s2_rdy_s[i]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IW'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // issue port
  always_comb begin
    iss_valid   = 1'b0;
    iss_opcode  = '0;
    iss_src1    = '0;
    iss_src2    = '0;
    iss_dst_tag = '0;
    if (sel_found_s) begin
      iss_valid   = 1'b1;
      iss_opcode  = opcode_r[sel_idx_s];
      iss_src1    = s1_val_s[sel_idx_s];
      iss_src2    = s2_val_s[sel_idx_s];
      iss_dst_tag = dst_r[sel_idx_s];
    end else begin
      iss_valid   = 1'b0;
    end
`ifdef ALU_RS_BYPASS_EN
    if (bypass_s) begin
      iss_valid   = 1'b1;
      iss_opcode  = disp_opcode;
      iss_src1    = disp_src1_val;
      iss_src2    = disp_src2_val;
      iss_dst_tag = disp_dst_tag;
    end else begin
      iss_valid   = iss_valid;
    end
`endif
  end

  // next queue contents: hold, collapse above the issued slot, then insert the dispatch
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      n_valid_s[i]  = valid_r[i];
      n_opcode_s[i] = opcode_r[i];
      n_dst_s[i]    = dst_r[i];
      n1_rdy_s[i]   = s1_rdy_s[i];
      n1_val_s[i]   = s1_val_s[i];
      n1_tag_s[i]   = s1_tag_s[i];
      n2_rdy_s[i]   = s2_rdy_s[i];
      n2_val_s[i]   = s2_val_s[i];
      n2_tag_s[i]   = s2_tag_s[i];
      if (iss_fire_s && (i >= int'(sel_idx_s))) begin
        if (i < DEPTH - 1) begin
          n_valid_s[i]  = valid_r[(i < DEPTH - 1) ? i + 1 : i];
          n_opcode_s[i] = opcode_r[(i < DEPTH - 1) ? i + 1 : i];
          n_dst_s[i]    = dst_r[(i < DEPTH - 1) ? i + 1 : i];
          n1_rdy_s[i]   = s1_rdy_s[(i < DEPTH - 1) ? i + 1 : i];
          n1_val_s[i]   = s1_val_s[(i < DEPTH - 1) ? i + 1 : i];
          n1_tag_s[i]   = s1_tag_s[(i < DEPTH - 1) ? i + 1 : i];
          n2_rdy_s[i]   = s2_rdy_s[(i < DEPTH - 1) ? i + 1 : i];
          n2_val_s[i]   = s2_val_s[(i < DEPTH - 1) ? i + 1 : i];
          n2_tag_s[i]   = s2_tag_s[(i < DEPTH - 1) ? i + 1 : i];
        end else begin
          n_valid_s[i]  = 1'b0;
          n_opcode_s[i] = '0;
          n_dst_s[i]    = '0;
          n1_rdy_s[i]   = 1'b0;
          n1_val_s[i]   = '0;
          n1_tag_s[i]   = '0;
          n2_rdy_s[i]   = 1'b0;
          n2_val_s[i]   = '0;
          n2_tag_s[i]   = '0;
        end
      end else begin
        n_valid_s[i]  = n_valid_s[i];
      end
      if (disp_fire_s && (CW'(i) == wpos_s)) begin
        n_valid_s[i]  = 1'b1;
        n_opcode_s[i] = disp_opcode;
        n_dst_s[i]    = disp_dst_tag;
        n1_rdy_s[i]   = disp_src1_rdy;
        n1_val_s[i]   = disp_src1_val;
        n1_tag_s[i]   = disp_src1_tag;
        n2_rdy_s[i]   = disp_src2_rdy;
        n2_val_s[i]   = disp_src2_val;
        n2_tag_s[i]   = disp_src2_tag;
      end else begin
        n_valid_s[i]  = n_valid_s[i];
      end
    end
  end

  // entry control fields and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= 1'b0;
        opcode_r[i] <= '0;
        dst_r[i]    <= '0;
      end
      count_r <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= 1'b0;
        opcode_r[i] <= '0;
        dst_r[i]    <= '0;
      end
      count_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= n_valid_s[i];
        opcode_r[i] <= n_opcode_s[i];
        dst_r[i]    <= n_dst_s[i];
      end
      count_r <= count_r + CW'(disp_fire_s) - CW'(iss_fire_s);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    alu_rs_src_wakeup #(.XLEN(XLEN), .TAG_W(TAG_W)) u_src1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(n_valid_s[g]),
      .in_rdy(n1_rdy_s[g]), .in_val(n1_val_s[g]), .in_tag(n1_tag_s[g]),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rdy(s1_rdy_s[g]), .val(s1_val_s[g]), .tag(s1_tag_s[g])
    );
    alu_rs_src_wakeup #(.XLEN(XLEN), .TAG_W(TAG_W)) u_src2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(n_valid_s[g]),
      .in_rdy(n2_rdy_s[g]), .in_val(n2_val_s[g]), .in_tag(n2_tag_s[g]),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rdy(s2_rdy_s[g]), .val(s2_val_s[g]), .tag(s2_tag_s[g])
    );
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic        dv;
    logic [3:0]  op;
    logic        s1r;
    logic [31:0] s1v;
    logic [3:0]  s1t;
    logic        s2r;
    logic [31:0] s2v;
    logic [3:0]  s2t;
    logic [3:0]  dst;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        ir;
    logic        fl;
  } vin_t;

  typedef struct {
    vin_t        in;
    logic        e_iv;
    logic [3:0]  e_op;
    logic [31:0] e_s1;
    logic [31:0] e_s2;
    logic [3:0]  e_dst;
    logic [2:0]  e_cnt;
    logic        e_dr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush, disp_valid, disp_ready, disp_src1_rdy, disp_src2_rdy;
  logic [3:0]  disp_opcode, disp_src1_tag, disp_src2_tag, disp_dst_tag, cdb_tag;
  logic [31:0] disp_src1_val, disp_src2_val, cdb_data;
  logic        cdb_valid, iss_valid, iss_ready;
  logic [3:0]  iss_opcode, iss_dst_tag;
  logic [31:0] iss_src1, iss_src2;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_pass = 0;
  rs_entry_t q_m[$];
  vec_t tbl[18];

  always #5 clk = ~clk;

  alu_rs #(.DEPTH(DEPTH), .XLEN(32), .OP_W(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_val(disp_src1_val), .disp_src1_tag(disp_src1_tag),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_val(disp_src2_val), .disp_src2_tag(disp_src2_tag),
    .disp_dst_tag(disp_dst_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dst_tag(iss_dst_tag), .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vin_t idl(input logic ir);
    vin_t v;
    v = '{default: '0};
    v.ir = ir;
    return v;
  endfunction

  function automatic vin_t cdb(input logic ir, input logic [3:0] t, input logic [31:0] d);
    vin_t v;
    v = idl(ir);
    v.cv = 1'b1; v.ct = t; v.cd = d;
    return v;
  endfunction

  function automatic vin_t dsp(input logic [3:0] op, input logic s1r, input logic [31:0] s1v,
                               input logic [3:0] s1t, input logic s2r, input logic [31:0] s2v,
                               input logic [3:0] s2t, input logic [3:0] dst, input logic ir);
    vin_t v;
    v = idl(ir);
    v.dv = 1'b1; v.op = op; v.dst = dst;
    v.s1r = s1r; v.s1v = s1v; v.s1t = s1t;
    v.s2r = s2r; v.s2v = s2v; v.s2t = s2t;
    return v;
  endfunction

  function automatic vec_t mk(input vin_t in, input logic iv, input logic [3:0] op,
                              input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] dst,
                              input logic [2:0] cnt, input logic dr);
    vec_t r;
    r.in = in; r.e_iv = iv; r.e_op = op; r.e_s1 = s1; r.e_s2 = s2;
    r.e_dst = dst; r.e_cnt = cnt; r.e_dr = dr;
    return r;
  endfunction

  task automatic apply(input vin_t v);
    disp_valid = v.dv; disp_opcode = v.op; disp_dst_tag = v.dst;
    disp_src1_rdy = v.s1r; disp_src1_val = v.s1v; disp_src1_tag = v.s1t;
    disp_src2_rdy = v.s2r; disp_src2_val = v.s2v; disp_src2_tag = v.s2t;
    cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd;
    iss_ready = v.ir; flush = v.fl;
  endtask

  // reference: oldest entry whose operands are both present
  function automatic int model_sel();
    foreach (q_m[k]) if (q_m[k].src1.rdy && q_m[k].src2.rdy) return k;
    return -1;
  endfunction

  task automatic model_edge();
    int sel;
    bit dfire;
    rs_entry_t e;
    sel   = model_sel();
    dfire = disp_valid && (q_m.size() < DEPTH);
    if (flush) begin
      q_m.delete();
    end else begin
      if (sel >= 0 && iss_ready) q_m.delete(sel);
      if (dfire) begin
        e.valid = 1'b1; e.opcode = disp_opcode; e.dst_tag = disp_dst_tag;
        e.src1 = '{disp_src1_rdy, disp_src1_val, disp_src1_tag};
        e.src2 = '{disp_src2_rdy, disp_src2_val, disp_src2_tag};
        q_m.push_back(e);
      end
      if (cdb_valid) begin
        foreach (q_m[k]) begin
          if (!q_m[k].src1.rdy && q_m[k].src1.tag == cdb_tag) q_m[k].src1 = '{1'b1, cdb_data, cdb_tag};
          if (!q_m[k].src2.rdy && q_m[k].src2.tag == cdb_tag) q_m[k].src2 = '{1'b1, cdb_data, cdb_tag};
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input int cyc);
    int sel;
    sel = model_sel();
    chk($sformatf("rnd%0d_iss_valid", cyc), iss_valid, (sel >= 0));
    if (sel >= 0) begin
      chk($sformatf("rnd%0d_opcode", cyc), iss_opcode, q_m[sel].opcode);
      chk($sformatf("rnd%0d_src1", cyc), iss_src1, q_m[sel].src1.val);
      chk($sformatf("rnd%0d_src2", cyc), iss_src2, q_m[sel].src2.val);
      chk($sformatf("rnd%0d_dst", cyc), iss_dst_tag, q_m[sel].dst_tag);
    end
    chk($sformatf("rnd%0d_count", cyc), count, q_m.size());
    chk($sformatf("rnd%0d_disp_ready", cyc), disp_ready, (q_m.size() < DEPTH));
  endtask

  // checks issue/occupancy outputs against hand-derived values
  task automatic chk_out(input string nm, input logic iv, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [3:0] dst, input logic [2:0] cnt);
    chk({nm, "_iv"}, iss_valid, iv);
    if (iv) begin
      chk({nm, "_s1"}, iss_src1, s1);
      chk({nm, "_s2"}, iss_src2, s2);
      chk({nm, "_dst"}, iss_dst_tag, dst);
    end
    chk({nm, "_cnt"}, count, cnt);
  endtask

  initial begin
    tbl[0]  = mk(dsp(ALU_ADD, 1, 3, 0, 1, 4, 0, 5, 1), 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(idl(1), 1, ALU_ADD, 3, 4, 5, 1, 1);
    tbl[2]  = mk(dsp(ALU_SUB, 0, 0, 2, 1, 9, 0, 6, 1), 0, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(idl(1), 0, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(cdb(1, 2, 6), 0, 0, 0, 0, 0, 1, 1);
    tbl[5]  = mk(idl(1), 1, ALU_SUB, 6, 9, 6, 1, 1);
    tbl[6]  = mk(dsp(ALU_AND, 0, 0, 7, 1, 1, 0, 8, 1), 0, 0, 0, 0, 0, 0, 1);
    tbl[6].in.cv = 1'b1; tbl[6].in.ct = 4'd7; tbl[6].in.cd = 32'h77;
    tbl[7]  = mk(idl(1), 1, ALU_AND, 32'h77, 1, 8, 1, 1);
    tbl[8]  = mk(dsp(ALU_OR, 1, 10, 0, 1, 11, 0, 1, 0), 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(dsp(ALU_OR, 1, 20, 0, 1, 21, 0, 2, 0), 1, ALU_OR, 10, 11, 1, 1, 1);
    tbl[10] = mk(dsp(ALU_OR, 1, 30, 0, 1, 31, 0, 3, 0), 1, ALU_OR, 10, 11, 1, 2, 1);
    tbl[11] = mk(dsp(ALU_OR, 1, 40, 0, 1, 41, 0, 4, 0), 1, ALU_OR, 10, 11, 1, 3, 1);
    tbl[12] = mk(dsp(ALU_OR, 1, 50, 0, 1, 51, 0, 9, 0), 1, ALU_OR, 10, 11, 1, 4, 0);
    tbl[13] = mk(dsp(ALU_OR, 1, 60, 0, 1, 61, 0, 10, 1), 1, ALU_OR, 10, 11, 1, 4, 0);
    tbl[14] = mk(idl(1), 1, ALU_OR, 20, 21, 2, 3, 1);
    tbl[15] = mk(idl(1), 1, ALU_OR, 30, 31, 3, 2, 1);
    tbl[16] = mk(idl(1), 1, ALU_OR, 40, 41, 4, 1, 1);
    tbl[17] = mk(idl(0), 0, 0, 0, 0, 0, 0, 1);

    apply(idl(0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_opcode", iss_opcode, 0);
    chk("rst_src1", iss_src1, 0);
    chk("rst_src2", iss_src2, 0);
    chk("rst_dst", iss_dst_tag, 0);
    chk("rst_count", count, 0);
    chk("rst_disp_ready", disp_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].in);
      @(negedge clk);
      chk($sformatf("v%0d_iss_valid", i), iss_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) begin
        chk($sformatf("v%0d_opcode", i), iss_opcode, tbl[i].e_op);
        chk($sformatf("v%0d_src1", i), iss_src1, tbl[i].e_s1);
        chk($sformatf("v%0d_src2", i), iss_src2, tbl[i].e_s2);
        chk($sformatf("v%0d_dst", i), iss_dst_tag, tbl[i].e_dst);
      end
      chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("v%0d_disp_ready", i), disp_ready, tbl[i].e_dr);
      adv();
    end

    // A waits, B ready, C waits on the same tag: B leaves from the middle, C collapses down
    apply(dsp(ALU_SLL, 0, 0, 3, 0, 0, 3, 11, 1)); @(negedge clk); chk_out("ab0", 0, 0, 0, 0, 0); adv();
    apply(dsp(ALU_SRL, 1, 100, 0, 1, 200, 0, 12, 1)); @(negedge clk); chk_out("ab1", 0, 0, 0, 0, 1); adv();
    apply(dsp(ALU_SLT, 0, 0, 3, 1, 32'h55, 0, 13, 1)); @(negedge clk); chk_out("ab2", 1, 100, 200, 12, 2); adv();
    apply(cdb(1, 3, 32'h33)); @(negedge clk); chk_out("ab3", 0, 0, 0, 0, 2); adv();
    apply(idl(1)); @(negedge clk); chk_out("ab4", 1, 32'h33, 32'h33, 11, 2); adv();
    @(negedge clk); chk_out("ab5", 1, 32'h33, 32'h55, 13, 1); adv();
    @(negedge clk); chk_out("ab6", 0, 0, 0, 0, 0); adv();

    // flush with three entries and a colliding dispatch
    for (int i = 1; i <= 3; i++) begin
      apply(dsp(ALU_XOR, 1, i, 0, 1, i + 16, 0, 4'(i), 0)); @(negedge clk); adv();
    end
    apply(dsp(ALU_XOR, 1, 7, 0, 1, 8, 0, 4, 0));
    flush = 1'b1;
    @(negedge clk); chk_out("fl0", 1, 1, 17, 1, 3); adv();
    apply(idl(0)); @(negedge clk); chk_out("fl1", 0, 0, 0, 0, 0);
    chk("fl1_disp_ready", disp_ready, 1); adv();

    // asynchronous reset while an entry is stalled
    apply(dsp(ALU_ADD, 1, 32'hA, 0, 1, 32'hB, 0, 5, 0)); @(negedge clk); adv();
    apply(idl(0)); @(negedge clk); chk_out("ar0", 1, 32'hA, 32'hB, 5, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar1_iss_valid", iss_valid, 0);
    chk("ar1_src1", iss_src1, 0);
    chk("ar1_dst", iss_dst_tag, 0);
    chk("ar1_count", count, 0);
    chk("ar1_disp_ready", disp_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q_m.delete();

    for (int c = 0; c < 400; c++) begin
      vin_t v;
      v.dv  = ($urandom_range(0, 1) == 1);
      v.op  = 4'($urandom_range(0, 7));
      v.s1r = ($urandom_range(0, 1) == 1);
      v.s1v = $urandom;
      v.s1t = 4'($urandom_range(0, 3));
      v.s2r = ($urandom_range(0, 1) == 1);
      v.s2v = $urandom;
      v.s2t = 4'($urandom_range(0, 3));
      v.dst = 4'($urandom_range(0, 15));
      v.cv  = ($urandom_range(0, 9) < 4);
      v.ct  = 4'($urandom_range(0, 3));
      v.cd  = $urandom;
      v.ir  = ($urandom_range(0, 9) < 7);
      v.fl  = ($urandom_range(0, 49) == 0);
      apply(v);
      @(negedge clk);
      check_model(c);
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
